dual_port_ram: RTL and testbench



---
 rtl/dual_port_ram.sv | 75 +++++++
 tb/tb_dual_port_ram.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dual_port_ram.sv
// dual_port_ram: one write port and one registered read port sharing a single clock.
// Every word has a "written" flag. Reset clears the flags and the read outputs but
// leaves the word storage alone, so stale words read back as 0 with rd_err set.
// Optional macro DUAL_PORT_RAM_BYPASS_EN: a write and a read to the same address in
// the same cycle return the incoming write data instead of the old contents.
module dual_port_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] wr_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  rd_err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      written;
  logic                  bypass_hit;

  // Same-cycle write/read collision detection (forwarding build only)
  always_comb begin
    bypass_hit = 1'b0;
`ifdef DUAL_PORT_RAM_BYPASS_EN
    bypass_hit = write && (wr_address == rd_address);
`endif
  end

  // Word storage: no reset; writes are ignored while reset is held
  always_ff @(posedge clock) begin
    if (resetn && write) begin
      mem[wr_address] <= data_in;
    end
  end

  // Written flags: cleared asynchronously, set by each accepted write
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      written <= '0;
    end else if (write) begin
      written[wr_address] <= 1'b1;
    end
  end

  // Registered read port: one-cycle latency, flags unwritten locations
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else if (read) begin
      rd_valid <= 1'b1;
      if (bypass_hit) begin
        data_out <= data_in;
        rd_err   <= 1'b0;
      end else if (written[rd_address]) begin
        data_out <= mem[rd_address];
        rd_err   <= 1'b0;
      end else begin
        data_out <= '0;
        rd_err   <= 1'b1;
      end
    end else begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: scoreboard bench for dual_port_ram (default 64x4096 build).
module tb_dual_port_ram;

  localparam int DW = 64;
  localparam int AW = 12;
  localparam int DEPTH = 4096;
`ifdef DUAL_PORT_RAM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn;
  logic          write;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] data_in;
  logic          read;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          rd_err;

  dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .write(write), .wr_address(wr_address),
    .data_in(data_in), .read(read), .rd_address(rd_address),
    .data_out(data_out), .rd_valid(rd_valid), .rd_err(rd_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mmem [DEPTH];
  bit            mflag [DEPTH];
  logic [DW-1:0] last_data;
  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectation, then check after the edge
  task automatic do_cycle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic r, input logic [AW-1:0] ra, input string tag);
    exp_t e;
    write = w; wr_address = wa; data_in = wd;
    read = r; rd_address = ra;
    if (r) begin
      if (BYP && w && (wa == ra)) begin
        e.d = wd; e.e = 1'b0;
      end else if (mflag[ra]) begin
        e.d = mmem[ra]; e.e = 1'b0;
      end else begin
        e.d = '0; e.e = 1'b1;
      end
      sb.push_back(e);
    end
    if (w) begin
      mmem[wa] = wd;
      mflag[wa] = 1'b1;
    end
    @(posedge clock);
    #1;
    write = 1'b0;
    read = 1'b0;
    if (r) begin
      check({tag, "_valid"}, {63'd0, rd_valid}, 64'd1);
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        check({tag, "_data"}, data_out, e.d);
        check({tag, "_err"}, {63'd0, rd_err}, {63'd0, e.e});
        last_data = e.d;
      end
    end else begin
      check({tag, "_idle_valid"}, {63'd0, rd_valid}, 64'd0);
      check({tag, "_idle_err"}, {63'd0, rd_err}, 64'd0);
      check({tag, "_idle_hold"}, data_out, last_data);
    end
  endtask

  task automatic model_reset();
    for (int unsigned i = 0; i < DEPTH; i++) mflag[i] = 1'b0;
    sb.delete();
    last_data = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;
    resetn = 1'b0; write = 1'b0; read = 1'b0;
    wr_address = '0; rd_address = '0; data_in = '0;
    model_reset();
    // Strobes during reset are ignored
    write = 1'b1; wr_address = 12'h005; data_in = 64'h1234;
    read = 1'b1; rd_address = 12'h005;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rst_data", data_out, 64'd0);
    check("rst_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_err", {63'd0, rd_err}, 64'd0);
    write = 1'b0; read = 1'b0;
    resetn = 1'b1;

    // Never-written location (also proves the in-reset write was dropped)
    do_cycle(0, '0, '0, 1, 12'h005, "unwritten");
    do_cycle(0, '0, '0, 0, '0, "idle0");

    // Write then read with one-cycle latency
    do_cycle(1, 12'h0FF, 64'hDEAD_BEEF_0123_4567, 0, '0, "wr0ff");
    do_cycle(0, '0, '0, 1, 12'h0FF, "rd0ff");

    // Address boundaries, back-to-back reads
    do_cycle(1, 12'h000, 64'h1, 0, '0, "wr000");
    do_cycle(1, 12'hFFF, 64'h2, 0, '0, "wrfff");
    do_cycle(0, '0, '0, 1, 12'h000, "b2b0");
    do_cycle(0, '0, '0, 1, 12'hFFF, "b2b1");
    do_cycle(0, '0, '0, 0, '0, "idle1");

    // Same-address collision
    do_cycle(1, 12'h010, 64'hAA, 0, '0, "preload");
    do_cycle(1, 12'h010, 64'hBB, 1, 12'h010, "collide");
    do_cycle(0, '0, '0, 1, 12'h010, "after_coll");
    do_cycle(1, 12'h011, 64'hCC, 1, 12'h011, "collide_unwr");

    // Different addresses in the same cycle
    do_cycle(1, 12'h012, 64'h77, 1, 12'h0FF, "concur");
    do_cycle(0, '0, '0, 1, 12'h012, "concur_rb");

    // Mid-cycle reset: outputs clear at once, pending read suppressed
    do_cycle(1, 12'h020, 64'h55, 0, '0, "wr020");
    do_cycle(0, '0, '0, 1, 12'h020, "rd020");
    read = 1'b1; rd_address = 12'h020;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_data", data_out, 64'd0);
    check("arst_valid", {63'd0, rd_valid}, 64'd0);
    check("arst_err", {63'd0, rd_err}, 64'd0);
    write = 1'b1; wr_address = 12'h030; data_in = 64'h99;
    @(posedge clock); #1;
    check("arst_hold_valid", {63'd0, rd_valid}, 64'd0);
    write = 1'b0; read = 1'b0;
    model_reset();
    #2;
    resetn = 1'b1;
    do_cycle(0, '0, '0, 1, 12'h020, "post_rst");
    do_cycle(0, '0, '0, 1, 12'h030, "rst_wr_drop");
    do_cycle(1, 12'h020, 64'h66, 0, '0, "rewrite");
    do_cycle(0, '0, '0, 1, 12'h020, "rewrite_rb");

    // Random concurrent traffic: writes in 0x100 region, reads from 0x200 region
    for (int unsigned i = 0; i < 8; i++)
      do_cycle(1, 12'h200 + i[AW-1:0], {$urandom, $urandom}, 0, '0, "pre200");
    for (int unsigned i = 0; i < 100; i++) begin
      ra = 12'h200 + AW'($urandom_range(0, 8));
      wd = {$urandom, $urandom};
      do_cycle(1, 12'h100 + AW'(i % 8), wd, 1, ra, "rand");
    end
    for (int unsigned i = 0; i < 8; i++)
      do_cycle(0, '0, '0, 1, 12'h100 + i[AW-1:0], "rand_rb");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
